// File: rtl/sram_async_ctrl.sv
// Asynchronous SRAM controller: single-cycle valid/ready requests to registered SRAM strobes.
// Optional macro SRAM_CTRL_POSTED_WRITE_EN posts writes through a one-deep write buffer.
module sram_async_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_rvalid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_wdone,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dq_o,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_dq_oe,
  output logic                  sram_cs_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);

  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int MAX_WAIT = (MAX_RW > TURN_CYC) ? MAX_RW : TURN_CYC;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_TURN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_o_q, dq_o_d;
  logic                dq_oe_q, dq_oe_d;
  logic                cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_pend_q, rvalid_pend_d;
  logic                rvalid_q, rvalid_d;
  logic                wdone_q, wdone_d;

  logic                accept;
  logic                start_rd, start_wr;
  logic [ADDR_W-1:0]   src_addr;
  logic [DATA_W-1:0]   src_wdata;
  logic [BE_W-1:0]     src_be;

`ifdef SRAM_CTRL_POSTED_WRITE_EN
  logic                buf_full_q, buf_full_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_wdata_q, buf_wdata_d;
  logic [BE_W-1:0]     buf_be_q, buf_be_d;
  logic                rreq_pend_q, rreq_pend_d;
  logic [ADDR_W-1:0]   rreq_addr_q, rreq_addr_d;
  logic                rd_from_req;
`endif

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    dq_o_d        = dq_o_q;
    dq_oe_d       = dq_oe_q;
    cs_n_d        = cs_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    be_n_d        = be_n_q;
    rdata_d       = rdata_q;
    rvalid_pend_d = 1'b0;
    rvalid_d      = rvalid_pend_q;
    wdone_d       = 1'b0;
    start_rd      = 1'b0;
    start_wr      = 1'b0;
    src_addr      = req_addr;
    src_wdata     = req_wdata;
    src_be        = req_be;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    buf_full_d    = buf_full_q;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    buf_be_d      = buf_be_q;
    rreq_pend_d   = rreq_pend_q;
    rreq_addr_d   = rreq_addr_q;
    rd_from_req   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef SRAM_CTRL_POSTED_WRITE_EN
        // A buffered write is always older than any pending read, so draining it first keeps RAW order.
        if (buf_full_q) begin
          start_wr  = 1'b1;
          src_addr  = buf_addr_q;
          src_wdata = buf_wdata_q;
          src_be    = buf_be_q;
        end else if (rreq_pend_q) begin
          start_rd  = 1'b1;
          src_addr  = rreq_addr_q;
        end else if (accept && !req_we) begin
          start_rd    = 1'b1;
          rd_from_req = 1'b1;
        end
`else
        if (accept) begin
          start_wr = req_we;
          start_rd = !req_we;
        end
`endif
      end
      S_RD: begin
        if (cnt_q == '0) begin
          state_d       = S_IDLE;
          cs_n_d        = 1'b1;
          oe_n_d        = 1'b1;
          be_n_d        = '1;
          rdata_d       = sram_dq_i;
          rvalid_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = WR_LAST;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WR_HOLD: begin
        wdone_d = 1'b1;
        cs_n_d  = 1'b1;
        be_n_d  = '1;
        dq_oe_d = 1'b0;
        if (TURN_CYC > 0) begin
          state_d = S_TURN;
          cnt_d   = TURN_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        dq_oe_d = 1'b0;
      end
    endcase

    if (start_rd) begin
      state_d = S_RD;
      cnt_d   = RD_LAST;
      addr_d  = src_addr;
      cs_n_d  = 1'b0;
      oe_n_d  = 1'b0;
      be_n_d  = '0;
      dq_oe_d = 1'b0;
    end
    if (start_wr) begin
      state_d = S_WR_SETUP;
      addr_d  = src_addr;
      dq_o_d  = src_wdata;
      be_n_d  = ~src_be;
      cs_n_d  = 1'b0;
      dq_oe_d = 1'b1;
    end

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    if (start_wr) begin
      buf_full_d = 1'b0;
    end
    if (start_rd && !rd_from_req) begin
      rreq_pend_d = 1'b0;
    end
    if (accept && req_we) begin
      buf_full_d  = 1'b1;
      buf_addr_d  = req_addr;
      buf_wdata_d = req_wdata;
      buf_be_d    = req_be;
    end
    if (accept && !req_we && !rd_from_req) begin
      rreq_pend_d = 1'b1;
      rreq_addr_d = req_addr;
    end
    // Idle FSM can always take one more request; a busy one only while both slots are free.
    ready_d = (state_d == S_IDLE) ? !rreq_pend_d : (!buf_full_d && !rreq_pend_d);
`else
    ready_d = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      addr_q        <= '0;
      dq_o_q        <= '0;
      dq_oe_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      be_n_q        <= '1;
      rdata_q       <= '0;
      rvalid_pend_q <= 1'b0;
      rvalid_q      <= 1'b0;
      wdone_q       <= 1'b0;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
      buf_full_q    <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      buf_be_q      <= '0;
      rreq_pend_q   <= 1'b0;
      rreq_addr_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      addr_q        <= addr_d;
      dq_o_q        <= dq_o_d;
      dq_oe_q       <= dq_oe_d;
      cs_n_q        <= cs_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      be_n_q        <= be_n_d;
      rdata_q       <= rdata_d;
      rvalid_pend_q <= rvalid_pend_d;
      rvalid_q      <= rvalid_d;
      wdone_q       <= wdone_d;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
      buf_full_q    <= buf_full_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      buf_be_q      <= buf_be_d;
      rreq_pend_q   <= rreq_pend_d;
      rreq_addr_q   <= rreq_addr_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign rsp_rvalid = rvalid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_wdone  = wdone_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl with a behavioural 256Kx16 SRAM and a response scoreboard.
// Build with SRAM_CTRL_POSTED_WRITE_EN to exercise the posted-write path instead of the pin-timing tests.
module tb_sram_async_ctrl;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int RD_WAIT  = 2;
  localparam int WR_WAIT  = 2;
  localparam int TURN_CYC = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_rvalid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_wdone;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i = 16'hDEAD;
  logic              sram_dq_oe;
  logic              sram_cs_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [1:0]        sram_be_n;

  sram_async_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_rvalid(rsp_rvalid), .rsp_rdata(rsp_rdata), .rsp_wdone(rsp_wdone),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Behavioural SRAM: lane writes while we_n is low, read data valid half a cycle after oe_n falls.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 2; b++) begin
        if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] <= sram_dq_o[8*b +: 8];
      end
    end
  end
  always @(negedge clk) begin
    sram_dq_i <= (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
  end

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wd_q[$];
  int      last_rv_cyc = 0;
  int      last_wd_cyc = 0;

  logic [35:0] prev_bus = '0;
  logic        prev_strb = 1'b0;

  // Response scoreboard plus bus stability check while any strobe is active.
  always @(negedge clk) begin
    if (prev_strb && (!sram_oe_n || !sram_we_n))
      check("bus_stable", {28'd0, sram_addr, sram_dq_o, sram_be_n}, {28'd0, prev_bus});
    prev_strb <= (!sram_oe_n || !sram_we_n);
    prev_bus  <= {sram_addr, sram_dq_o, sram_be_n};
    if (rsp_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", rsp_rvalid, 1'b0);
      end else begin
        check("rdata", rsp_rdata, rd_q[0].data);
        if (rd_q[0].due >= 0) check("rvalid_cycle", cyc, rd_q[0].due);
        void'(rd_q.pop_front());
        last_rv_cyc <= cyc;
      end
    end
    if (rsp_wdone === 1'b1) begin
      if (wd_q.size() == 0) begin
        check("wdone_unexpected", rsp_wdone, 1'b0);
      end else begin
        if (wd_q[0] >= 0) check("wdone_cycle", cyc, wd_q[0]);
        void'(wd_q.pop_front());
        last_wd_cyc <= cyc;
      end
    end
  end

  logic [5:0] pins;
  assign pins = {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n};

  // Called and returns at posedge+1; acc is the edge on which the request was accepted.
  task automatic issue(input logic we, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit hold, output int acc);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      if (req_ready === 1'b1) acc = cyc + 1;
      @(posedge clk);
      #1;
    end
    if (acc < 0) check("accept_timeout", req_ready, 1'b1);
    if (!hold) req_valid = 1'b0;
    $display("txn %s addr=%05h wdata=%04h be=%b accepted at cycle %0d",
             we ? "WR" : "RD", a, d, be, acc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (rd_q.size() + wd_q.size()) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", rd_q.size() + wd_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] wr_seq [5];
  int acc, prev_acc;

  initial begin
    wr_seq = '{6'b011100, 6'b010100, 6'b010100, 6'b011100, 6'b111011};
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;

    // Reset: 3 cycles held, then released.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_pins", pins, 6'b111011);
    check("rst_rvalid", rsp_rvalid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_pins", pins, 6'b111011);
    check("post_rst_addr", sram_addr, 18'h0);
    check("post_rst_dq", sram_dq_o, 16'h0);
    check("post_rst_rdata", rsp_rdata, 16'h0);
    check("post_rst_wdone", rsp_wdone, 1'b0);

`ifndef SRAM_CTRL_POSTED_WRITE_EN
    // Write then read back with the exact pin sequence.
    issue(1'b1, 18'h00010, 16'hBEEF, 2'b11, 1'b0, acc);
    wd_q.push_back(acc + WR_WAIT + 2);
    check("wr_addr", sram_addr, 18'h00010);
    check("wr_dq", sram_dq_o, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_pins_%0d", i), pins, wr_seq[i]);
      check($sformatf("wr_ready_%0d", i), req_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    check("turn_done_ready", req_ready, 1'b1);
    issue(1'b0, 18'h00010, 16'h0, 2'b00, 1'b0, acc);
    rd_q.push_back('{data: 16'hBEEF, due: acc + RD_WAIT + 1});
    check("rd_pins", pins, 6'b001000);
    check("rd_addr", sram_addr, 18'h00010);
    wait_drain();

    // Top address and byte-lane masking.
    issue(1'b1, 18'h3FFFF, 16'h1234, 2'b11, 1'b0, acc);
    wd_q.push_back(acc + WR_WAIT + 2);
    issue(1'b1, 18'h3FFFF, 16'hAB56, 2'b01, 1'b0, acc);
    wd_q.push_back(acc + WR_WAIT + 2);
    check("byte_be_n", sram_be_n, 2'b10);
    issue(1'b0, 18'h3FFFF, 16'h0, 2'b00, 1'b0, acc);
    rd_q.push_back('{data: 16'h1256, due: acc + RD_WAIT + 1});
    check("top_addr", sram_addr, 18'h3FFFF);
    wait_drain();

    // Back-to-back reads with req_valid held high.
    for (int i = 0; i < 4; i++) mem[18'h00100 + i] = 16'hA000 + 16'(i * 16'h0111);
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 18'h00100 + 18'(i), 16'h0, 2'b00, (i < 3), acc);
      rd_q.push_back('{data: 16'hA000 + 16'(i * 16'h0111), due: acc + RD_WAIT + 1});
      check($sformatf("b2b_addr_%0d", i), sram_addr, 18'h00100 + 18'(i));
      if (i > 0) check($sformatf("b2b_spacing_%0d", i), acc - prev_acc, RD_WAIT + 1);
      prev_acc = acc;
    end
    wait_drain();

    // Reset during the write pulse abandons the write without a response.
    issue(1'b1, 18'h00020, 16'h5555, 2'b11, 1'b0, acc);
    @(posedge clk);
    #1;
    check("pulse_we_n", sram_we_n, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_pins", pins, 6'b111011);
    check("abort_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_release", req_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_wdone", wd_q.size(), 0);
`else
    // Posted write followed immediately by a read of the same address.
    issue(1'b1, 18'h00005, 16'hCAFE, 2'b11, 1'b0, acc);
    wd_q.push_back(-1);
    check("posted_ready", req_ready, 1'b1);
    prev_acc = acc;
    issue(1'b0, 18'h00005, 16'h0, 2'b00, 1'b0, acc);
    rd_q.push_back('{data: 16'hCAFE, due: -1});
    check("posted_rd_accept", acc - prev_acc, 1);
    wait_drain();
    check("wdone_before_rvalid", (last_wd_cyc < last_rv_cyc), 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
